// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the stall/bubble controller: instruction latches,
// redirect, multdiv handshake in; latch enables, nop inserts, multdiv control out.
interface hazard_stall_ctrl_if;
  logic [31:0] fd_insn;
  logic [31:0] dx_insn;
  logic        branch_taken;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_excep_in;

  logic        stall_fd;
  logic        stall_dx;
  logic        bubble_dx;
  logic        bubble_xm;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        md_valid;
  logic [31:0] md_data;
  logic        md_exception;

  modport master (
    output fd_insn, dx_insn, branch_taken, md_resultRDY, md_result, md_excep_in,
    input  stall_fd, stall_dx, bubble_dx, bubble_xm, ctrl_MULT, ctrl_DIV,
           md_valid, md_data, md_exception
  );

  modport slave (
    input  fd_insn, dx_insn, branch_taken, md_resultRDY, md_result, md_excep_in,
    output stall_fd, stall_dx, bubble_dx, bubble_xm, ctrl_MULT, ctrl_DIV,
           md_valid, md_data, md_exception
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: handles lw-use hazards
// (one stall + one bubble) and multi-cycle mul/div sequencing in X.
module hazard_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] md_data_q, md_data_d;
  logic        md_exc_q, md_exc_d;

  logic stall_fd, stall_dx, bubble_dx, bubble_xm, ctrl_mult, ctrl_div, md_valid;

  // Instruction field decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       fd_uses_rs, fd_uses_rt, fd_uses_rd;
  logic       dx_is_lw, dx_is_mul, dx_is_div, md_start, load_use;

  assign fd_op  = bus.fd_insn[31:27];
  assign fd_rd  = bus.fd_insn[26:22];
  assign fd_rs  = bus.fd_insn[21:17];
  assign fd_rt  = bus.fd_insn[16:12];
  assign fd_alu = bus.fd_insn[6:2];
  assign dx_op  = bus.dx_insn[31:27];
  assign dx_rd  = bus.dx_insn[26:22];
  assign dx_alu = bus.dx_insn[6:2];

  logic unused_bits;
  assign unused_bits = ^{bus.fd_insn[11:7], bus.fd_insn[1:0],
                         bus.dx_insn[21:7], bus.dx_insn[1:0]};

  assign fd_uses_rs = (fd_op == 5'b00000) || (fd_op == 5'b00101) || (fd_op == 5'b01000) ||
                      (fd_op == 5'b00111) || (fd_op == 5'b00010) || (fd_op == 5'b00110);
  assign fd_uses_rt = (fd_op == 5'b00000) && (fd_alu[4:1] != 4'b0010);
  assign fd_uses_rd = (fd_op == 5'b00111) || (fd_op == 5'b00010) ||
                      (fd_op == 5'b00110) || (fd_op == 5'b00100);

  assign dx_is_lw  = (dx_op == 5'b01000);
  assign dx_is_mul = (dx_op == 5'b00000) && (dx_alu == 5'b00110);
  assign dx_is_div = (dx_op == 5'b00000) && (dx_alu == 5'b00111);
  assign md_start  = (dx_is_mul || dx_is_div) && !bus.branch_taken;

  assign load_use = dx_is_lw && (dx_rd != 5'd0) && !bus.branch_taken &&
                    ((fd_uses_rs && fd_rs == dx_rd) ||
                     (fd_uses_rt && fd_rt == dx_rd) ||
                     (fd_uses_rd && fd_rd == dx_rd));

  // State, counter and multdiv result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      md_data_q <= '0;
      md_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_data_q <= md_data_d;
      md_exc_q  <= md_exc_d;
    end
  end

  // Next-state and stall/bubble/start decode; everything forced low in reset
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_data_d = md_data_q;
    md_exc_d  = md_exc_q;
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_dx = 1'b0;
    bubble_xm = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    md_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          ctrl_mult = dx_is_mul;
          ctrl_div  = dx_is_div;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
          cnt_d     = '0;
          state_d   = S_BUSY;
        end else if (load_use) begin
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      S_BUSY: begin
        stall_fd  = 1'b1;
        stall_dx  = 1'b1;
        bubble_xm = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (bus.md_resultRDY) begin
          md_data_d = bus.md_result;
          md_exc_d  = bus.md_excep_in;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          md_data_d = '0;
          md_exc_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        md_valid = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      stall_fd  = 1'b0;
      stall_dx  = 1'b0;
      bubble_dx = 1'b0;
      bubble_xm = 1'b0;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      md_valid  = 1'b0;
    end
  end

  assign bus.stall_fd     = stall_fd;
  assign bus.stall_dx     = stall_dx;
  assign bus.bubble_dx    = bubble_dx;
  assign bus.bubble_xm    = bubble_xm;
  assign bus.ctrl_MULT    = ctrl_mult;
  assign bus.ctrl_DIV     = ctrl_div;
  assign bus.md_valid     = md_valid;
  assign bus.md_data      = reset ? '0 : md_data_q;
  assign bus.md_exception = reset ? 1'b0 : md_exc_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, hand-written multdiv
// sequences and randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int unsigned TO = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // flags: {stall_fd, stall_dx, bubble_dx, bubble_xm, ctrl_MULT, ctrl_DIV, md_valid, md_exception}
  logic [7:0]  s_flags, m_flags;
  logic [31:0] s_data, m_dat;

  // behavioural model state
  bit          m_active, m_done, m_exc;
  int unsigned m_elapsed;
  logic [31:0] m_data;

  typedef struct {
    bit          rst;
    logic [31:0] fd, dx;
    bit          bt, rdy;
    logic [31:0] res;
    bit          exc;
    logic [7:0]  ef;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[$];

  logic [4:0] ops[9] = '{5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd1, 5'd3};
  logic [4:0] alus[6] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7};

  function automatic logic [31:0] rt_i(int rd, int rs, int rt, logic [4:0] alu);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, alu, 2'd0};
  endfunction

  function automatic logic [31:0] it_i(logic [4:0] op, int rd, int rs, int imm);
    return {op, 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic vec_t mk(bit rst, logic [31:0] fd, logic [31:0] dx, bit bt, bit rdy,
                              logic [31:0] res, bit exc, logic [7:0] ef, logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.fd = fd; v.dx = dx; v.bt = bt; v.rdy = rdy;
    v.res = res; v.exc = exc; v.ef = ef; v.ed = ed;
    return v;
  endfunction

  // Does instruction i read register r as a source?
  function automatic bit reads(logic [31:0] i, logic [4:0] r);
    logic [4:0] op, alu;
    op  = i[31:27];
    alu = i[6:2];
    if ((op inside {5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6}) && i[21:17] == r) return 1'b1;
    if (op == 5'd0 && !(alu inside {5'd4, 5'd5}) && i[16:12] == r) return 1'b1;
    if ((op inside {5'd7, 5'd2, 5'd6, 5'd4}) && i[26:22] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_md(logic [31:0] i);
    return i[31:27] == 5'd0 && (i[6:2] == 5'd6 || i[6:2] == 5'd7);
  endfunction

  task automatic model_expect(output logic [7:0] f, output logic [31:0] d);
    logic [31:0] dx;
    dx = bus.dx_insn;
    d  = m_data;
    if (reset) begin
      f = '0;
      d = '0;
    end else if (m_done)
      f = {6'b0, 1'b1, m_exc};
    else if (m_active)
      f = {4'b1101, 3'b000, m_exc};
    else if (is_md(dx) && !bus.branch_taken)
      f = {4'b1101, dx[6:2] == 5'd6, dx[6:2] == 5'd7, 1'b0, m_exc};
    else if (dx[31:27] == 5'd8 && dx[26:22] != 5'd0 && !bus.branch_taken &&
             reads(bus.fd_insn, dx[26:22]))
      f = {4'b1010, 3'b000, m_exc};
    else
      f = {7'b0, m_exc};
  endtask

  task automatic model_update();
    if (reset) begin
      m_active = 0; m_done = 0; m_exc = 0; m_data = '0; m_elapsed = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (bus.md_resultRDY) begin
        m_data = bus.md_result; m_exc = bus.md_excep_in; m_active = 0; m_done = 1;
      end else if (m_elapsed == TO - 1) begin
        m_data = '0; m_exc = 1; m_active = 0; m_done = 1;
      end else
        m_elapsed++;
    end else if (is_md(bus.dx_insn) && !bus.branch_taken) begin
      m_active = 1; m_elapsed = 0;
    end
  endtask

  task automatic cycle(bit rst, logic [31:0] fd, logic [31:0] dx, bit bt, bit rdy,
                       logic [31:0] res, bit exc);
    @(negedge clock);
    reset = rst; bus.fd_insn = fd; bus.dx_insn = dx; bus.branch_taken = bt;
    bus.md_resultRDY = rdy; bus.md_result = res; bus.md_excep_in = exc;
    #1;
    s_flags = {bus.stall_fd, bus.stall_dx, bus.bubble_dx, bus.bubble_xm,
               bus.ctrl_MULT, bus.ctrl_DIV, bus.md_valid, bus.md_exception};
    s_data  = bus.md_data;
    model_expect(m_flags, m_dat);
    @(posedge clock);
    model_update();
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic mcheck(string name);
    check({name, "_flags"}, 32'(s_flags), 32'(m_flags));
    check({name, "_data"}, s_data, m_dat);
  endtask

  function automatic logic [31:0] rand_insn();
    case ($urandom_range(0, 5))
      0: return it_i(5'd8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
      1: return rt_i($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 5'd6);
      2: return rt_i($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 5'd7);
      3: return rt_i($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     alus[$urandom_range(0, 5)]);
      default: return it_i(ops[$urandom_range(0, 8)], $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 15));
    endcase
  endfunction

  logic [31:0] LW5, LW0, ADD, ADD0, SLL, SW5, MUL, DIV, NOP;
  int unsigned n_stall, n_mult;

  initial begin
    bus.fd_insn = '0; bus.dx_insn = '0; bus.branch_taken = 0;
    bus.md_resultRDY = 0; bus.md_result = '0; bus.md_excep_in = 0;
    LW5  = it_i(5'd8, 5, 2, 0);
    LW0  = it_i(5'd8, 0, 2, 0);
    ADD  = rt_i(7, 5, 1, 5'd0);
    ADD0 = rt_i(7, 0, 1, 5'd0);
    SLL  = rt_i(7, 3, 5, 5'd4);
    SW5  = it_i(5'd7, 5, 9, 4);
    MUL  = rt_i(4, 2, 3, 5'd6);
    DIV  = rt_i(4, 2, 3, 5'd7);
    NOP  = '0;

    // ---- directed vector table (one row per cycle) ----
    tbl.push_back(mk(1, ADD,  MUL, 0, 1, 32'd5,  0, 8'b0000_0000, 32'd0));
    tbl.push_back(mk(0, ADD,  LW5, 0, 0, 32'd0,  0, 8'b1010_0000, 32'd0));
    tbl.push_back(mk(0, ADD,  NOP, 0, 0, 32'd0,  0, 8'b0000_0000, 32'd0));
    tbl.push_back(mk(0, ADD0, LW0, 0, 0, 32'd0,  0, 8'b0000_0000, 32'd0));
    tbl.push_back(mk(0, SLL,  LW5, 0, 0, 32'd0,  0, 8'b0000_0000, 32'd0));
    tbl.push_back(mk(0, SW5,  LW5, 0, 0, 32'd0,  0, 8'b1010_0000, 32'd0));
    tbl.push_back(mk(0, ADD,  LW5, 1, 0, 32'd0,  0, 8'b0000_0000, 32'd0));
    tbl.push_back(mk(0, ADD,  MUL, 1, 0, 32'd0,  0, 8'b0000_0000, 32'd0));
    tbl.push_back(mk(0, ADD,  MUL, 0, 0, 32'd0,  0, 8'b1101_1000, 32'd0));
    tbl.push_back(mk(0, ADD,  MUL, 0, 1, 32'd7,  0, 8'b1101_0000, 32'd0));
    tbl.push_back(mk(0, ADD,  MUL, 0, 0, 32'd0,  0, 8'b0000_0010, 32'd7));
    tbl.push_back(mk(0, ADD,  NOP, 0, 1, 32'd99, 0, 8'b0000_0000, 32'd7));
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].fd, tbl[i].dx, tbl[i].bt, tbl[i].rdy, tbl[i].res, tbl[i].exc);
      check($sformatf("tbl%0d_flags", i), 32'(s_flags), 32'(tbl[i].ef));
      check($sformatf("tbl%0d_data", i), s_data, tbl[i].ed);
    end

    // ---- mul, result 42 after 17 busy cycles ----
    n_stall = 0; n_mult = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(0, ADD, MUL, 0, i == 17, 32'd42, 0);
      mcheck("mul42");
      n_stall += s_flags[7];
      n_mult  += s_flags[3];
    end
    cycle(0, ADD, MUL, 0, 0, 32'd0, 0);
    mcheck("mul42_done");
    check("mul42_valid", 32'(s_flags[1]), 32'd1);
    check("mul42_value", s_data, 32'd42);
    n_stall += s_flags[7];
    check("mul42_stall_cycles", n_stall, 32'd18);
    check("mul42_start_pulses", n_mult, 32'd1);
    cycle(0, ADD, NOP, 0, 0, 32'd0, 0);
    check("mul42_valid_drop", 32'(s_flags[1]), 32'd0);
    check("mul42_hold", s_data, 32'd42);

    // ---- div with exception, then clean div ----
    for (int i = 0; i < 4; i++) begin
      cycle(0, NOP, DIV, 0, i == 3, 32'd5, i == 3);
      mcheck("divx");
    end
    cycle(0, NOP, DIV, 0, 0, 32'd0, 0);
    mcheck("divx_done");
    check("divx_exc", 32'(s_flags[0]), 32'd1);
    check("divx_valid", 32'(s_flags[1]), 32'd1);
    cycle(0, NOP, NOP, 0, 0, 32'd0, 0);
    mcheck("divx_gap");
    for (int i = 0; i < 3; i++) begin
      cycle(0, NOP, DIV, 0, i == 2, 32'd9, 0);
      mcheck("div");
    end
    cycle(0, NOP, DIV, 0, 0, 32'd0, 0);
    check("div_exc_clear", 32'(s_flags[0]), 32'd0);
    check("div_value", s_data, 32'd9);

    // ---- timeout, then RDY on the timeout cycle ----
    n_stall = 0;
    for (int i = 0; i < TO + 1; i++) begin
      cycle(0, NOP, MUL, 0, 0, 32'd0, 0);
      mcheck("tmo");
      n_stall += s_flags[7];
    end
    cycle(0, NOP, MUL, 0, 0, 32'd0, 0);
    mcheck("tmo_done");
    check("tmo_stall_cycles", n_stall, TO + 1);
    check("tmo_exc", 32'(s_flags[0]), 32'd1);
    check("tmo_data", s_data, 32'd0);
    for (int i = 0; i < TO + 1; i++) begin
      cycle(0, NOP, MUL, 0, i == TO, 32'd77, 0);
      mcheck("tmo_rdy");
    end
    cycle(0, NOP, NOP, 0, 0, 32'd0, 0);
    check("tmo_rdy_exc", 32'(s_flags[0]), 32'd0);
    check("tmo_rdy_data", s_data, 32'd77);

    // ---- reset mid-BUSY, late result dropped, branch-cancelled start ----
    for (int i = 0; i < 6; i++) begin
      cycle(0, NOP, MUL, 0, 0, 32'd0, 0);
      mcheck("rst_busy");
    end
    cycle(1, NOP, MUL, 0, 0, 32'd0, 0);
    check("rst_flags", 32'(s_flags), 32'd0);
    check("rst_data", s_data, 32'd0);
    cycle(0, NOP, NOP, 0, 0, 32'd0, 0);
    mcheck("rst_after");
    cycle(0, NOP, NOP, 0, 1, 32'd123, 1);
    check("rst_late_flags", 32'(s_flags), 32'd0);
    cycle(0, NOP, MUL, 1, 0, 32'd0, 0);
    check("late_dropped", s_data, 32'd0);
    check("bt_no_start", 32'(s_flags), 32'd0);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0, rand_insn(), rand_insn(),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom, 1'($urandom_range(0, 1)));
      mcheck("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
